// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle multiply/divide with private HI/LO; MULDIV_SIGNED_EN adds signed MULT/DIV.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             PCclk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Adat,
  input  logic [WIDTH-1:0] Bdat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_step;
  logic [WIDTH-1:0] b_r, a_mag, b_mag, res_hi, res_lo, drem;
  logic [WIDTH:0] msum, dshift;
  logic is_mul, is_div, dge, last;
`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, neg_x, neg_r, div_r;
  logic [2*WIDTH-1:0] p_neg;
  assign is_mul = op == 3'b000 || op == 3'b010;
  assign is_div = op == 3'b001 || op == 3'b011;
  assign a_neg  = op[1] && Adat[WIDTH-1];
  assign b_neg  = op[1] && Bdat[WIDTH-1];
  assign a_mag  = a_neg ? -Adat : Adat;
  assign b_mag  = b_neg ? -Bdat : Bdat;
  assign p_neg  = -p;
  // low half of a negated product equals the negated low half, so LO shares one fix-up
  assign res_lo = neg_x ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign res_hi = div_r ? (neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH])
                        : (neg_x ? p_neg[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH]);
`else
  assign is_mul = op == 3'b000;
  assign is_div = op == 3'b001;
  assign a_mag  = Adat;
  assign b_mag  = Bdat;
  assign res_lo = p[WIDTH-1:0];
  assign res_hi = p[2*WIDTH-1:WIDTH];
`endif
  assign busy = state != IDLE;
  // p holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    last    = cnt == CNT_W'(WIDTH-1);
    msum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : '0);
    dshift  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    dge     = dshift >= {1'b0, b_r};
    drem    = dshift[WIDTH-1:0] - b_r;
    p_step  = state == MUL ? {msum, p[WIDTH-1:1]} : {dge ? drem : dshift[WIDTH-1:0], p[WIDTH-2:0], dge};
    state_n = state == IDLE ? (start && is_mul ? MUL : start && is_div ? DIV : IDLE)
            : state == FIN  ? IDLE
            : last          ? FIN : state;
  end
  always_ff @(posedge PCclk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      p     <= '0;
      b_r   <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_x <= 1'b0;
      neg_r <= 1'b0;
      div_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done  <= state == FIN;
      if (state == IDLE) begin
        cnt <= '0;
        if (start && op == 3'b100) hi <= Adat;
        if (start && op == 3'b101) lo <= Adat;
        if (start && (is_mul || is_div)) begin
          p   <= {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
          b_r <= is_mul ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
          // a zero divisor keeps the all-ones quotient unsigned
          neg_x <= (a_neg ^ b_neg) && !(is_div && Bdat == '0);
          neg_r <= a_neg;
          div_r <= is_div;
`endif
        end
      end else if (state == FIN) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        p   <= p_step;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random + directed scoreboard bench for muldiv_unit; honours MULDIV_SIGNED_EN.
module tb_muldiv_unit;
`ifdef MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic PCclk = 0, rst = 1, start = 0, busy, done;
  logic [2:0] op = 0;
  logic [31:0] Adat = 0, Bdat = 0, hi, lo, exp_hi = 0, exp_lo = 0;
  logic [63:0] sb[$];
  int compared = 0, mismatched = 0;

  muldiv_unit dut (.PCclk(PCclk), .rst(rst), .start(start), .op(op), .Adat(Adat), .Bdat(Bdat),
                   .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 PCclk = ~PCclk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic bit iterative(input logic [2:0] o);
    return o == 3'd0 || o == 3'd1 || (SGN && (o == 3'd2 || o == 3'd3));
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    int ia, ib;
    if (o == 3'd0) return {32'd0, a} * {32'd0, b};
    if (o == 3'd2) begin
      sa = longint'($signed(a));
      sb2 = longint'($signed(b));
      return 64'(sa * sb2);
    end
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (o == 3'd1) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    ia = a;
    ib = b;
    return {32'(ia % ib), 32'(ia / ib)};
  endfunction

  always @(negedge PCclk) begin
    if (!rst && done) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with nothing outstanding", hi, lo);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({hi, lo} !== e || busy !== 1'b0) begin
          mismatched++;
          $display("FAIL result: got hi_lo=%h busy=%b want %h busy=0", {hi, lo}, busy, e);
        end
      end
    end
  end

  task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    op = o; Adat = a; Bdat = b; start = 1;
    @(posedge PCclk); #1;
    start = 0; Adat = $urandom; Bdat = $urandom;
    if (iterative(o)) begin
      r = model(o, a, b);
      sb.push_back(r);
      check("busy_accept", {63'd0, busy}, 64'd1);
      check("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end else begin
      if (o == 3'd4) exp_hi = a;
      if (o == 3'd5) exp_lo = a;
      check("busy_idle", {63'd0, busy}, 64'd0);
      check("direct_hilo", {hi, lo}, {exp_hi, exp_lo});
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge PCclk); #1;
      n++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge PCclk);
    #1 rst = 0;
    go(3'd4, 32'hDEADBEEF, 0);
    go(3'd5, 32'hCAFEF00D, 0);
    rst = 1;
    @(posedge PCclk); #1;
    rst = 0;
    exp_hi = 0; exp_lo = 0;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);

    go(3'd0, 32'hFFFFFFFF, 32'h2);
    for (int i = 1; i <= 33; i++) begin
      @(posedge PCclk); #1;
      check("lat_busy", {63'd0, busy}, {63'd0, i < 33});
      check("lat_done", {63'd0, done}, {63'd0, i == 33});
    end

    go(3'd1, 32'd100, 32'd7);
    repeat (9) @(posedge PCclk);
    op = 3'd1; Adat = 32'd999; Bdat = 32'd3; start = 1;
    @(posedge PCclk); #1;
    start = 0;
    wait_idle();

    go(3'd1, 32'd5, 32'd0);
    wait_idle();

    go(3'd2, -32'sd3, 32'd5);             wait_idle();
    go(3'd3, -32'sd7, 32'd2);             wait_idle();
    go(3'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    go(3'd3, -32'sd9, 32'd0);             wait_idle();

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: b = $urandom;
      endcase
      go(3'($urandom_range(0, 7)), a, b);
      wait_idle();
    end

    go(3'd0, $urandom, $urandom);
    repeat (14) @(posedge PCclk);
    rst = 1;
    @(posedge PCclk); #1;
    rst = 0;
    sb.delete();
    exp_hi = 0; exp_lo = 0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (40) @(posedge PCclk);
    #1 check("abort_no_result", {hi, lo}, 64'd0);
    go(3'd5, 32'h1234, 0);

    rst = 1; op = 3'd0; Adat = 7; Bdat = 9; start = 1;
    @(posedge PCclk); #1;
    rst = 0; start = 0;
    exp_hi = 0; exp_lo = 0;
    check("rst_wins", {hi, lo, 31'd0, busy}, 96'd0);
    @(posedge PCclk); #1;
    check("rst_wins_busy", {63'd0, busy}, 64'd0);

    repeat (3) @(posedge PCclk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
